// File: rtl/matmul_scratchpad_pkg.sv
// matmul_scratchpad shared definitions: engine memory opcodes, FSM state
// encoding, requester identity and the default word width.

`ifndef TYPE_BW
`define TYPE_BW 32
`endif

package matmul_scratchpad_pkg;

  localparam int DATA_W_DEF = `TYPE_BW;

  localparam logic [1:0] MEM_OP_NONE  = 2'b00;
  localparam logic [1:0] MEM_OP_READ  = 2'b01;
  localparam logic [1:0] MEM_OP_WRITE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_ENG  = 1'b1
  } requester_t;

  // 2'b10 is reserved and behaves like "no operation".
  function automatic logic is_eng_req(input logic [1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/matmul_scratchpad_if.sv
// Engine memory port and Wishbone-classic slave port of the scratchpad.
// master = engine/host side, slave = scratchpad side.

interface matmul_scratchpad_if import matmul_scratchpad_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [1:0]        eng_mem_operation;
  logic [31:0]       eng_addr_i;
  logic [DATA_W-1:0] eng_data_i;
  logic [DATA_W-1:0] eng_data_o;
  logic              eng_opdone;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [31:0]       wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic [DATA_W-1:0] wbs_dat_o;
  logic              wbs_ack_o;

  logic              err_o;

  modport master (
    output eng_mem_operation, eng_addr_i, eng_data_i,
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  eng_data_o, eng_opdone, wbs_dat_o, wbs_ack_o, err_o
  );

  modport slave (
    input  eng_mem_operation, eng_addr_i, eng_data_i,
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output eng_data_o, eng_opdone, wbs_dat_o, wbs_ack_o, err_o
  );

endinterface

// File: rtl/matmul_scratchpad_scratch_ram.sv
// Single-port synchronous storage array. Write-first: a write also returns
// the written word on rdata. Kept separate so a hard macro can replace it.

module scratch_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Array access; contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/matmul_scratchpad.sv
// Scratchpad shared by the matrix engine memory port and a Wishbone host.
// Optional build macro: SCRATCH_BOUNDS_CHECK_EN (out-of-range accesses skip
// the array, read as 0 and set a sticky err_o). Default build wraps
// addresses modulo DEPTH and ties err_o low.
//
// state  | meaning
// IDLE   | arbitrate; latch winner's op, address and write data
// ACCESS | count ACC_LAT cycles; array accessed on the last edge
// DONE   | one-cycle opdone (engine) or ack (host) with the word
// GAP    | keep a held request from being re-sampled before it can move on

module matmul_scratchpad import matmul_scratchpad_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 64,
  parameter int ACC_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  matmul_scratchpad_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q;
  logic [1:0]        cnt_q;
  requester_t        sel_q;
  requester_t        rr_last_q;
  logic              we_q;
  logic              oob_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              opdone_q;
  logic              ack_q;

  logic              eng_req, host_req, grant_eng_d;
  logic              we_d, oob_d;
  logic [AW-1:0]     addr_d;
  logic [DATA_W-1:0] wdata_d;

  logic              ram_en, ram_we;
  logic [DATA_W-1:0] ram_rdata, rd_word;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{bus.eng_addr_i, bus.wbs_adr_i};

  // Request detection, round-robin pick and capture of the winner's access.
  always_comb begin
    eng_req     = is_eng_req(bus.eng_mem_operation);
    host_req    = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
    grant_eng_d = eng_req & (~host_req | (rr_last_q == REQ_HOST));
    if (grant_eng_d) begin
      we_d    = (bus.eng_mem_operation == MEM_OP_WRITE);
      addr_d  = bus.eng_addr_i[AW-1:0];
      wdata_d = bus.eng_data_i;
`ifdef SCRATCH_BOUNDS_CHECK_EN
      oob_d   = (bus.eng_addr_i >= 32'(DEPTH));
`else
      oob_d   = 1'b0;
`endif
    end else begin
      we_d    = bus.wbs_we_i;
      addr_d  = bus.wbs_adr_i[AW+1:2];
      wdata_d = bus.wbs_dat_i;
`ifdef SCRATCH_BOUNDS_CHECK_EN
      oob_d   = (bus.wbs_adr_i[31:2] >= 30'(DEPTH));
`else
      oob_d   = 1'b0;
`endif
    end
  end

  // Access FSM with registered completion pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= REQ_HOST;
      rr_last_q <= REQ_HOST;
      we_q      <= 1'b0;
      oob_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      opdone_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      opdone_q <= 1'b0;
      ack_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (eng_req || host_req) begin
            sel_q     <= grant_eng_d ? REQ_ENG : REQ_HOST;
            rr_last_q <= grant_eng_d ? REQ_ENG : REQ_HOST;
            we_q      <= we_d;
            oob_q     <= oob_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= 2'(ACC_LAT - 1);
            state_q   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == 2'd0) begin
            opdone_q <= (sel_q == REQ_ENG);
            ack_q    <= (sel_q == REQ_HOST);
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        ST_DONE: state_q <= ST_GAP;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Array is touched only on the edge that enters DONE.
  assign ram_en = (state_q == ST_ACCESS) && (cnt_q == 2'd0);
  assign ram_we = ram_en & we_q & ~oob_q;

  scratch_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign rd_word = oob_q ? '0 : ram_rdata;

  assign bus.eng_opdone = opdone_q;
  assign bus.eng_data_o = opdone_q ? rd_word : '0;
  assign bus.wbs_ack_o  = ack_q;
  assign bus.wbs_dat_o  = ack_q ? rd_word : '0;

`ifdef SCRATCH_BOUNDS_CHECK_EN
  logic err_q;

  // Sticky out-of-range flag, set as the offending access completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (ram_en && oob_q) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule
